// File: rtl/bnn_roll_par.sv
// Rolled two-layer binarized classifier: PAR hidden neurons per cycle, then one class per cycle with running argmax.
// Optional `score` output port enabled by macro BNN_ROLL_SCORE_EN.
module bnn_roll_par #(
  parameter int FEAT_CNT   = 11,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 7,
  parameter int PAR        = 1,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  Weights0 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] Weights1 = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(CLASS_CNT)-1:0]  prediction
`ifdef BNN_ROLL_SCORE_EN
  ,
  output logic [$clog2(HIDDEN_CNT+1)-1:0] score
`endif
);

  localparam int NG  = (HIDDEN_CNT + PAR - 1) / PAR;
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int CW  = $clog2(CLASS_CNT);
  localparam int SW  = $clog2(HIDDEN_CNT + 1);
  localparam int AW  = FEAT_BITS + $clog2(FEAT_CNT + 1) + 1;
  localparam int HIW = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HID, ST_CLS} state_t;

  state_t                        state_q, state_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q, feat_d;
  logic [HIDDEN_CNT-1:0]         hidden_q, hidden_d;
  logic [GW-1:0]                 grp_q, grp_d;
  logic [CW-1:0]                 cls_q, cls_d;
  logic [CW-1:0]                 best_q, best_d;
  logic [SW-1:0]                 bscore_q, bscore_d;
  logic [CW-1:0]                 pred_q, pred_d;
  logic [SW-1:0]                 score_q, score_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [HIDDEN_CNT-1:0]         hid_upd_s;
  logic [HIDDEN_CNT-1:0]         w1row_s;
  logic [HIDDEN_CNT-1:0]         xn_s;
  logic [SW-1:0]                 pop_s;
  logic [CW-1:0]                 win_cls_s;
  logic [SW-1:0]                 win_sc_s;

  // Hidden-layer group: sign of the +/-feature sum for neurons g*PAR .. g*PAR+PAR-1
  always_comb begin
    int                  h_int;
    logic [HIW-1:0]      hidx;
    logic [FEAT_CNT-1:0] wrow;
    logic [AW-1:0]       acc;
    hid_upd_s = hidden_q;
    h_int     = 0;
    hidx      = '0;
    wrow      = '0;
    acc       = '0;
    for (int p = 0; p < PAR; p++) begin
      h_int = int'(grp_q) * PAR + p;
      hidx  = h_int[HIW-1:0];
      wrow  = FEAT_CNT'(Weights0 >> (h_int * FEAT_CNT));
      acc   = '0;
      for (int f = 0; f < FEAT_CNT; f++) begin
        if (wrow[f]) begin
          acc = acc + AW'(feat_q[f*FEAT_BITS +: FEAT_BITS]);
        end else begin
          acc = acc - AW'(feat_q[f*FEAT_BITS +: FEAT_BITS]);
        end
      end
      if (h_int < HIDDEN_CNT) begin
        hid_upd_s[hidx] = ~acc[AW-1];
      end else begin
        hid_upd_s = hid_upd_s;
      end
    end
  end

  // Output layer: agreement popcount for class cls_q and the running argmax (ties keep the lower index)
  always_comb begin
    w1row_s = HIDDEN_CNT'(Weights1 >> (int'(cls_q) * HIDDEN_CNT));
    xn_s    = ~(hidden_q ^ w1row_s);
    pop_s   = '0;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      pop_s = pop_s + SW'(xn_s[h]);
    end
    if ((cls_q == '0) || (pop_s > bscore_q)) begin
      win_cls_s = cls_q;
      win_sc_s  = pop_s;
    end else begin
      win_cls_s = best_q;
      win_sc_s  = bscore_q;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    feat_d   = feat_q;
    hidden_d = hidden_q;
    grp_d    = grp_q;
    cls_d    = cls_q;
    best_d   = best_q;
    bscore_d = bscore_q;
    pred_d   = pred_q;
    score_d  = score_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          feat_d   = features;
          hidden_d = '0;
          grp_d    = '0;
          state_d  = ST_HID;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HID: begin
        hidden_d = hid_upd_s;
        if (grp_q == GW'(NG - 1)) begin
          state_d  = ST_CLS;
          cls_d    = '0;
          best_d   = '0;
          bscore_d = '0;
        end else begin
          grp_d    = grp_q + GW'(1);
        end
      end
      ST_CLS: begin
        best_d   = win_cls_s;
        bscore_d = win_sc_s;
        if (cls_q == CW'(CLASS_CNT - 1)) begin
          pred_d  = win_cls_s;
          score_d = win_sc_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cls_d   = cls_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      feat_q   <= '0;
      hidden_q <= '0;
      grp_q    <= '0;
      cls_q    <= '0;
      best_q   <= '0;
      bscore_q <= '0;
      pred_q   <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      hidden_q <= hidden_d;
      grp_q    <= grp_d;
      cls_q    <= cls_d;
      best_q   <= best_d;
      bscore_q <= bscore_d;
      pred_q   <= pred_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign prediction = pred_q;
`ifdef BNN_ROLL_SCORE_EN
  assign score      = score_q;
`endif

endmodule

// File: tb/tb_bnn_roll_par.sv
// Bench for bnn_roll_par: six instances (varied PAR / weight sets) checked every cycle against a behavioural model.
// Score checks are compiled in only with BNN_ROLL_SCORE_EN.
module tb_bnn_roll_par;

  localparam int NI = 6;

  logic        clk;
  logic        rst;
  logic        start;
  logic [43:0] features;
  logic [NI-1:0] busy_v;
  logic [NI-1:0] done_v;
  logic [2:0]  pred_v [NI];
`ifdef BNN_ROLL_SCORE_EN
  logic [5:0]  score_v [NI];
`endif

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int lat  [NI];
  int dcnt [NI];

  function automatic logic [511:0] prbs(input logic [31:0] seed);
    logic [511:0] r;
    logic [31:0]  x;
    r = '0;
    x = seed;
    for (int k = 0; k < 512; k++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      r[k] = x[3];
    end
    return r;
  endfunction

  function automatic int par_of(input int i);
    case (i)
      1:       return 3;
      2:       return 40;
      5:       return 7;
      default: return 1;
    endcase
  endfunction

  function automatic logic [439:0] w0_of(input int i);
    case (i)
      3:       return '1;
      4:       return '0;
      default: return 440'(prbs(32'h1D2C_3B4A));
    endcase
  endfunction

  function automatic logic [279:0] w1_of(input int i);
    logic [279:0] r;
    r = '0;
    case (i)
      3: r[3*40 +: 40] = '1;
      4: begin
        for (int c = 0; c < 7; c++) begin
          r[c*40 +: 40] = (c == 1) ? 40'h0 : (c == 6) ? {40{1'b1}} : {20'hFFFFF, 20'h00000};
        end
      end
      5:       r = '0;
      default: r = 280'(prbs(32'h5EED_0F0F));
    endcase
    return r;
  endfunction

  // Reference classifier: {winning score, winning class}
  function automatic logic [8:0] classify(input logic [43:0] ft, input logic [439:0] w0, input logic [279:0] w1);
    logic [39:0] hid;
    int s, fv, sc, best, bs;
    for (int h = 0; h < 40; h++) begin
      s = 0;
      for (int f = 0; f < 11; f++) begin
        fv = int'(ft[f*4 +: 4]);
        s  = w0[h*11+f] ? s + fv : s - fv;
      end
      hid[h] = (s >= 0);
    end
    best = 0;
    bs   = -1;
    for (int c = 0; c < 7; c++) begin
      sc = 0;
      for (int h = 0; h < 40; h++) begin
        if (hid[h] == w1[c*40+h]) sc++;
      end
      if (sc > bs) begin
        bs   = sc;
        best = c;
      end
    end
    return {bs[5:0], best[2:0]};
  endfunction

  for (genvar i = 0; i < NI; i++) begin : g_dut
    bnn_roll_par #(
      .PAR(par_of(i)),
      .Weights0(w0_of(i)),
      .Weights1(w1_of(i))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .features(features),
      .busy(busy_v[i]),
      .done(done_v[i]),
      .prediction(pred_v[i])
`ifdef BNN_ROLL_SCORE_EN
      ,
      .score(score_v[i])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: remaining-cycle countdown per instance, result computed at acceptance
  int         rem    [NI];
  logic [8:0] res    [NI];
  logic       done_m [NI];
  logic [2:0] pred_m [NI];
  logic [5:0] sc_m   [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        rem[i]    <= 0;
        done_m[i] <= 1'b0;
        pred_m[i] <= 3'd0;
        sc_m[i]   <= 6'd0;
      end else begin
        done_m[i] <= 1'b0;
        if (rem[i] == 0) begin
          if (start) begin
            rem[i] <= (40 + par_of(i) - 1) / par_of(i) + 7;
            res[i] <= classify(features, w0_of(i), w1_of(i));
          end
        end else begin
          rem[i] <= rem[i] - 1;
          if (rem[i] == 1) begin
            done_m[i] <= 1'b1;
            pred_m[i] <= res[i][2:0];
            sc_m[i]   <= res[i][8:3];
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("busy%0d", i), int'(busy_v[i]), int'(rem[i] != 0));
        check($sformatf("done%0d", i), int'(done_v[i]), int'(done_m[i]));
        check($sformatf("pred%0d", i), int'(pred_v[i]), int'(pred_m[i]));
`ifdef BNN_ROLL_SCORE_EN
        check($sformatf("score%0d", i), int'(score_v[i]), int'(sc_m[i]));
`endif
      end
    end
  end

  // One inference: start pulse, optional feature scrambling, extra start pulses and a reset at cycle rst_at
  task automatic run_inf(input logic [43:0] ft, input bit scramble, input bit pulses, input int rst_at);
    for (int i = 0; i < NI; i++) begin
      lat[i]  = -1;
      dcnt[i] = 0;
    end
    features = ft;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (done_v[i]) begin
          dcnt[i]++;
          if (lat[i] < 0) lat[i] = n;
        end
      end
      start = pulses && (n == 5 || n == 20);
      rst   = (n == rst_at);
      if (scramble) features = 44'({$urandom(), $urandom()});
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    logic [8:0] r;
    int held;
    rst      = 1'b1;
    start    = 1'b0;
    features = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", int'(busy_v), 0);
    check("rst_done", int'(done_v), 0);
    check("rst_pred0", int'(pred_v[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    r = classify(44'h0, w0_of(3), w1_of(3));
    check("mdl_win_cls", int'(r[2:0]), 3);
    check("mdl_win_sc", int'(r[8:3]), 40);
    r = classify({11{4'd5}}, w0_of(4), w1_of(4));
    check("mdl_sign_cls", int'(r[2:0]), 1);
    check("mdl_sign_sc", int'(r[8:3]), 40);

    run_inf(44'h0, 1'b0, 1'b0, -1);
    check("lat_par1", lat[0], 47);
    check("lat_par3", lat[1], 21);
    check("lat_par40", lat[2], 8);
    check("lat_par7", lat[5], 13);
    check("win_pred", int'(pred_v[3]), 3);
    check("sign0_pred", int'(pred_v[4]), 6);
    check("tie_pred", int'(pred_v[5]), 0);
`ifdef BNN_ROLL_SCORE_EN
    check("win_score", int'(score_v[3]), 40);
    check("sign0_score", int'(score_v[4]), 40);
`endif

    run_inf({11{4'd5}}, 1'b0, 1'b0, -1);
    check("sign5_pred", int'(pred_v[4]), 1);
`ifdef BNN_ROLL_SCORE_EN
    check("sign5_score", int'(score_v[4]), 40);
`endif

    for (int k = 0; k < 20; k++) begin
      run_inf(44'({$urandom(), $urandom()}), 1'b1, 1'b0, -1);
    end

    run_inf(44'({$urandom(), $urandom()}), 1'b0, 1'b1, -1);
    check("pulse_one_done", dcnt[0], 1);

    run_inf(44'({$urandom(), $urandom()}), 1'b1, 1'b0, 30);
    check("rst_no_done", dcnt[0], 0);
    check("rst_pred", int'(pred_v[0]), 0);

    run_inf(44'({$urandom(), $urandom()}), 1'b0, 1'b0, -1);
    check("after_rst_lat", lat[0], 47);

    held     = 0;
    features = 44'({$urandom(), $urandom()});
    start    = 1'b1;
    for (int n = 1; n <= 144; n++) begin
      @(negedge clk);
      if (done_v[0]) held++;
      features = 44'({$urandom(), $urandom()});
    end
    start = 1'b0;
    check("held_dones", held, 3);
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
